// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the shared-ALU arbiter and the
// result consumer. master = requesters/consumer side, slave = arbiter side.
interface alu_arbiter_if #(parameter int TAG_W = 4);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_funct, req1_funct;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_o;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_funct, req1_funct, req0_tag, req1_tag, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_o, rsp_src, rsp_tag
  );
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_funct, req1_funct, req0_tag, req1_tag, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_o, rsp_src, rsp_tag
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; round-robin on contention, single result
// register with full-throughput reload when the consumer drains it.
module team_alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  funct_i,
  output logic [31:0] y_o
);
  logic [4:0] sh;
  assign sh = b_i[4:0];

  always_comb begin
    y_o = '0;
    case (funct_i[2:0])
      3'd0: y_o = funct_i[3] ? (a_i - b_i) : (a_i + b_i);
      3'd1: y_o = a_i << sh;
      3'd2: y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      3'd3: y_o = {31'b0, a_i < b_i};
      3'd4: y_o = a_i ^ b_i;
      3'd5: begin
        // kept as separate branches so the signed shift isn't widened to unsigned
        if (funct_i[3]) y_o = $signed(a_i) >>> sh;
        else            y_o = a_i >> sh;
      end
      3'd6: y_o = a_i | b_i;
      3'd7: y_o = a_i & b_i;
      default: y_o = '0;
    endcase
  end
endmodule

module alu_arbiter #(parameter int TAG_W = 4) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_o_q, rsp_o_d;
  logic             rsp_src_q, rsp_src_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             last_grant_q, last_grant_d;

  logic        grant0, grant1, can_accept, xfer;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_funct;

  // last_grant_q == 1 means requester 1 went last, so requester 0 wins a tie
  assign grant0     = bus.req0_valid & (~bus.req1_valid | last_grant_q);
  assign grant1     = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
  assign can_accept = ~rsp_valid_q | bus.rsp_ready;

  assign bus.req0_ready = rst_n & grant0 & can_accept;
  assign bus.req1_ready = rst_n & grant1 & can_accept;
  assign xfer = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);

  assign alu_a     = grant1 ? bus.req1_a     : bus.req0_a;
  assign alu_b     = grant1 ? bus.req1_b     : bus.req0_b;
  assign alu_funct = grant1 ? bus.req1_funct : bus.req0_funct;

  team_alu u_alu (.a_i(alu_a), .b_i(alu_b), .funct_i(alu_funct), .y_o(alu_y));

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_o_d      = rsp_o_q;
    rsp_src_d    = rsp_src_q;
    rsp_tag_d    = rsp_tag_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_o_d      = alu_y;
      rsp_src_d    = grant1;
      rsp_tag_d    = grant1 ? bus.req1_tag : bus.req0_tag;
      last_grant_d = grant1;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_o_q      <= '0;
      rsp_src_q    <= 1'b0;
      rsp_tag_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_o_q      <= rsp_o_d;
      rsp_src_q    <= rsp_src_d;
      rsp_tag_q    <= rsp_tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_o     = rsp_o_q;
  assign bus.rsp_src   = rsp_src_q;
  assign bus.rsp_tag   = rsp_tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases plus random traffic scored against a
// transaction-level model of the arbiter and ALU.
module tb_alu_arbiter;
  localparam int TAG_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.TAG_W(TAG_W)) bus ();
  alu_arbiter #(.TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_run = 0, n_fail = 0;

  // reference state: what the result register should hold
  bit          m_vld;
  logic [31:0] m_o;
  int          m_src, m_last;
  logic [3:0]  m_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] f);
    int unsigned sh = b % 32;
    int sa = int'(a);
    int sb = int'(b);
    int r;
    case (f[2:0])
      3'd0: return f[3] ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (f[3]) begin r = sa >>> sh; return r; end
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_reset();
    m_vld = 0; m_o = '0; m_src = 0; m_tag = '0; m_last = 1;
  endtask

  // At the negedge: check DUT against model, then advance the model by one edge.
  task automatic cycle();
    int  winner;
    bit  can;
    @(negedge clk);
    can = !m_vld || bus.rsp_ready;
    if (bus.req0_valid && bus.req1_valid) winner = 1 - m_last;
    else if (bus.req0_valid)              winner = 0;
    else if (bus.req1_valid)              winner = 1;
    else                                  winner = -1;
    chk("ready0", 32'(bus.req0_ready), 32'(can && winner == 0));
    chk("ready1", 32'(bus.req1_ready), 32'(can && winner == 1));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_vld));
    chk("rsp_o", bus.rsp_o, m_o);
    chk("rsp_src", 32'(bus.rsp_src), 32'(m_src));
    chk("rsp_tag", 32'(bus.rsp_tag), 32'(m_tag));
    if (can && winner >= 0) begin
      m_vld = 1; m_src = winner; m_last = winner;
      m_o   = (winner == 0) ? ref_alu(bus.req0_a, bus.req0_b, bus.req0_funct)
                            : ref_alu(bus.req1_a, bus.req1_b, bus.req1_funct);
      m_tag = (winner == 0) ? bus.req0_tag : bus.req1_tag;
    end else if (bus.rsp_ready) begin
      m_vld = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_funct = '0; bus.req0_tag = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_funct = '0; bus.req1_tag = '0;
    bus.rsp_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    logic held_src;
    logic [31:0] held_o;
    idle_inputs();
    bus.req0_valid = 1;
    #2;
    chk("reset_ready0", 32'(bus.req0_ready), 32'd0);
    chk("reset_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_o", bus.rsp_o, 32'd0);
    chk("reset_tag", 32'(bus.rsp_tag), 32'd0);
    bus.req0_valid = 0;
    do_reset();

    // single add
    bus.req0_valid = 1; bus.req0_a = 5; bus.req0_b = 3; bus.req0_funct = 4'h0; bus.req0_tag = 2;
    cycle();
    bus.req0_valid = 0;
    chk("add_valid", 32'(bus.rsp_valid), 32'd1);
    chk("add_o", bus.rsp_o, 32'd8);
    chk("add_src", 32'(bus.rsp_src), 32'd0);
    chk("add_tag", 32'(bus.rsp_tag), 32'd2);

    // sub from requester 1
    bus.req1_valid = 1; bus.req1_a = 3; bus.req1_b = 5; bus.req1_funct = 4'h8; bus.req1_tag = 7;
    cycle();
    bus.req1_valid = 0;
    chk("sub_o", bus.rsp_o, 32'hFFFF_FFFE);
    chk("sub_src", 32'(bus.rsp_src), 32'd1);

    // arithmetic vs logical shift right
    bus.req0_valid = 1; bus.req0_a = 32'h8000_0000; bus.req0_b = 4; bus.req0_funct = 4'hD;
    cycle();
    chk("sra_o", bus.rsp_o, 32'hF800_0000);
    bus.req0_funct = 4'h5;
    cycle();
    chk("srl_o", bus.rsp_o, 32'h0800_0000);
    idle_inputs();
    cycle();

    // contention from reset: alternating grants, no bubbles
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 10; bus.req0_b = 1; bus.req0_tag = 1;
    bus.req1_valid = 1; bus.req1_a = 20; bus.req1_b = 2; bus.req1_tag = 9;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alt_valid", 32'(bus.rsp_valid), 32'd1);
      chk("alt_src", 32'(bus.rsp_src), 32'(i % 2));
    end

    // backpressure: hold result, then the other requester goes next
    bus.rsp_ready = 0;
    held_src = bus.rsp_src; held_o = bus.rsp_o;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_src", 32'(bus.rsp_src), 32'(held_src));
      chk("stall_o", bus.rsp_o, held_o);
    end
    bus.rsp_ready = 1;
    cycle();
    chk("post_stall_src", 32'(bus.rsp_src), 32'(!held_src));

    // reset asserted mid-stall between edges
    bus.rsp_ready = 0;
    cycle();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    bus.rsp_ready = 1;
    cycle();
    chk("post_rst_src", 32'(bus.rsp_src), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.req0_valid = ($urandom_range(0, 9) < 7);
      bus.req1_valid = ($urandom_range(0, 9) < 7);
      bus.rsp_ready  = ($urandom_range(0, 9) < 7);
      bus.req0_a = $urandom; bus.req0_b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
      bus.req1_a = $urandom; bus.req1_b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
      bus.req0_funct = 4'($urandom); bus.req1_funct = 4'($urandom);
      bus.req0_tag = 4'($urandom); bus.req1_tag = 4'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
